bip_ii: RTL and testbench
=========================

BIP_II -- requirements
Module: bip_ii

Interface
REQ-001 Parameter DATA_W, default 16, accumulator/data-memory word width; SHALL be >= ADDR_W.
REQ-002 Parameter ADDR_W, default 11, PC width, data-memory address width and operand width.
REQ-003 Parameter CNT_W, default 16, retired-instruction counter width.
REQ-004 Instruction word SHALL be 5+ADDR_W bits: opcode [ADDR_W+4:ADDR_W], operand [ADDR_W-1:0].
REQ-005 Clk  input  1  single clock; all state updates on rising edge.
REQ-006 Reset  input  1  reset, synchronous, active-high.
REQ-007 Enable  input  1  run enable; low stalls the core.
REQ-008 Instr  input  5+ADDR_W  instruction from external program memory, combinationally valid for current PC.
REQ-009 PC  output  ADDR_W  program counter, the fetch address for Instr.
REQ-010 Acc  output  DATA_W  accumulator contents.
REQ-011 Halt  output  1  high once HLT has executed.
REQ-012 Instr_Count  output  CNT_W  number of retired instructions.

Function
REQ-013 Core SHALL retire one instruction per cycle when Enable=1 and Halt=0 ("active cycle"); no pipeline, no bubbles.
REQ-014 Internal data memory SHALL hold 2^ADDR_W words of DATA_W bits: asynchronous read, synchronous write.
REQ-015 Imm SHALL be operand sign-extended to DATA_W; M SHALL be Mem[operand].
REQ-016 Opcodes, all on active cycles only: 00000 HLT: Halt<=1, PC unchanged; 00001 STO: Mem[operand]<=Acc; 00010 LD: Acc<=M; 00011 LDI: Acc<=Imm.
REQ-017 00100 ADD: Acc<=Acc+M; 00101 ADDI: Acc<=Acc+Imm; 00110 SUB: Acc<=Acc-M; 00111 SUBI: Acc<=Acc-Imm.
REQ-018 01000 AND / 01001 ANDI / 01010 OR / 01011 ORI / 01100 XOR / 01101 XORI: Acc<=Acc op M (resp. Imm), bitwise.
REQ-019 10000 BEQ: PC<=operand if Acc==0; 10001 BNE: PC<=operand if Acc!=0; 10010 JMP: PC<=operand unconditionally.
REQ-020 Every other opcode SHALL act as NOP: no state change except PC+1 and Instr_Count increment.
REQ-021 Arithmetic SHALL wrap modulo 2^DATA_W; no carry/overflow flags.
REQ-022 Non-taken branches and all non-branch, non-HLT instructions SHALL set PC<=PC+1, wrapping 2^ADDR_W-1 -> 0.
REQ-023 Branch condition SHALL use Acc value before the edge.
REQ-024 Instr_Count SHALL increment by 1 per retired instruction, HLT included, and saturate at 2^CNT_W-1.
REQ-025 Enable=0 SHALL freeze PC, Acc, Instr_Count, Halt, and memory (no STO write).
REQ-026 Halt=1 SHALL freeze all state regardless of Enable or Instr; only Reset clears Halt.
REQ-027 Outputs SHALL be driven directly from registers; Instr SHALL not combinationally affect any output.

Reset
REQ-028 Reset=1 at a rising edge SHALL set PC=0, Acc=0, Halt=0, Instr_Count=0, overriding any instruction, Enable or Halt in that cycle.
REQ-029 Reset SHALL NOT clear data memory; contents after power-up are undefined until written.
REQ-030 An STO presented in a Reset cycle SHALL NOT write memory.
REQ-031 First instruction retired after Reset deasserts SHALL be the one at address 0.

Verification
REQ-032 Reset with Enable=1 and JMP 0x005 on Instr -> next cycle PC=0, Acc=0, Halt=0, Instr_Count=0.
REQ-033 Program LDI 7; STO 3; LDI 0; ADD 3; ADDI -2 (0x7FE) -> after 5 edges Acc=0x0005, PC=5, Instr_Count=5.
REQ-034 LDI 0; BEQ 0x010 -> PC=0x010; then LDI 1; BNE 0x000 -> PC=0; then LDI 1; BEQ 0x020 -> PC=PC+1.
REQ-035 LDI 0; SUBI 1 -> Acc=0xFFFF; PC forced to 0x7FF via JMP, then NOP -> PC=0x000.
REQ-036 HLT at address 2 -> Halt=1, PC stays 2, Instr_Count stays 3 for 10 cycles under any Instr/Enable; Reset then clears all.
REQ-037 Enable=0 for 4 cycles mid-program with STO on Instr -> PC, Acc, count unchanged; later LD of that address returns prior value.

Source files
------------

// File: rtl/bip_ii.sv
// Accumulator core: one instruction retires per active cycle, with no pipeline.
// Enable low stalls the core. Halt freezes it until Reset. Every output comes straight from a register.
module bip_ii #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Enable,
    input  logic [ADDR_W+4:0] Instr,
    output logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] Acc,
    output logic              Halt,
    output logic [CNT_W-1:0]  Instr_Count
);

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;
    localparam logic [4:0] OP_AND  = 5'b01000;
    localparam logic [4:0] OP_ANDI = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ORI  = 5'b01011;
    localparam logic [4:0] OP_XOR  = 5'b01100;
    localparam logic [4:0] OP_XORI = 5'b01101;
    localparam logic [4:0] OP_BEQ  = 5'b10000;
    localparam logic [4:0] OP_BNE  = 5'b10001;
    localparam logic [4:0] OP_JMP  = 5'b10010;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic [4:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] mval;
    logic              active;
    logic [ADDR_W-1:0] next_pc;
    logic [DATA_W-1:0] next_acc;
    logic              next_halt;
    logic              mem_we;

    assign opcode  = Instr[ADDR_W+4:ADDR_W];
    assign operand = Instr[ADDR_W-1:0];
    assign imm     = DATA_W'($signed(operand));
    assign mval    = mem[operand];
    assign active  = Enable && !Halt;

    always_comb begin
        next_pc   = PC + ADDR_W'(1);
        next_acc  = Acc;
        next_halt = 1'b0;
        mem_we    = 1'b0;
        case (opcode)
            OP_HLT: begin
                next_halt = 1'b1;
                next_pc   = PC;
            end
            OP_STO:  mem_we   = 1'b1;
            OP_LD:   next_acc = mval;
            OP_LDI:  next_acc = imm;
            OP_ADD:  next_acc = Acc + mval;
            OP_ADDI: next_acc = Acc + imm;
            OP_SUB:  next_acc = Acc - mval;
            OP_SUBI: next_acc = Acc - imm;
            OP_AND:  next_acc = Acc & mval;
            OP_ANDI: next_acc = Acc & imm;
            OP_OR:   next_acc = Acc | mval;
            OP_ORI:  next_acc = Acc | imm;
            OP_XOR:  next_acc = Acc ^ mval;
            OP_XORI: next_acc = Acc ^ imm;
            // Branch conditions look at the accumulator as it stands before this edge.
            OP_BEQ: if (Acc == '0) next_pc = operand;
            OP_BNE: if (Acc != '0) next_pc = operand;
            OP_JMP: next_pc = operand;
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            PC          <= '0;
            Acc         <= '0;
            Halt        <= 1'b0;
            Instr_Count <= '0;
        end else if (active) begin
            PC   <= next_pc;
            Acc  <= next_acc;
            Halt <= next_halt;
            if (Instr_Count != {CNT_W{1'b1}})
                Instr_Count <= Instr_Count + CNT_W'(1);
        end
    end

    // Data memory keeps its contents across Reset; a store is blocked in a reset cycle.
    always_ff @(posedge Clk) begin
        if (!Reset && active && mem_we)
            mem[operand] <= Acc;
    end

endmodule

// File: tb/tb_bip_ii.sv
// Directed test of bip_ii. The program memory is modelled in the bench and can be overridden per cycle.
module tb_bip_ii;

    localparam logic [4:0] HLT = 5'b00000, STO = 5'b00001, LD = 5'b00010, LDI = 5'b00011;
    localparam logic [4:0] ADD = 5'b00100, ADDI = 5'b00101, SUB = 5'b00110, SUBI = 5'b00111;
    localparam logic [4:0] AND = 5'b01000, ANDI = 5'b01001, OR = 5'b01010, ORI = 5'b01011;
    localparam logic [4:0] XOR = 5'b01100, XORI = 5'b01101;
    localparam logic [4:0] BEQ = 5'b10000, BNE = 5'b10001, JMP = 5'b10010, NOP = 5'b10011;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Enable;
    logic [15:0] Instr;
    logic [10:0] PC;
    logic [15:0] Acc;
    logic        Halt;
    logic [15:0] Instr_Count;

    logic [10:0] s_pc;
    logic [15:0] s_acc;
    logic        s_halt;
    logic [2:0]  s_count;
    logic [15:0] s_instr;

    logic [15:0] prog [2048];
    logic        use_ovr;
    logic [15:0] ovr;

    int checks = 0;
    int passes = 0;

    assign Instr   = use_ovr ? ovr : prog[PC];
    assign s_instr = {NOP, 11'h000};

    bip_ii dut (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .Instr(Instr),
        .PC(PC), .Acc(Acc), .Halt(Halt), .Instr_Count(Instr_Count)
    );

    // Narrow counter instance so saturation is reachable in a few cycles.
    bip_ii #(.DATA_W(16), .ADDR_W(11), .CNT_W(3)) dut_s (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .Instr(s_instr),
        .PC(s_pc), .Acc(s_acc), .Halt(s_halt), .Instr_Count(s_count)
    );

    always #5 Clk = ~Clk;

    function automatic logic [15:0] ins(input logic [4:0] op, input logic [10:0] a);
        return {op, a};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 2048; i++) prog[i] = ins(NOP, 11'h000);
    endtask

    task automatic do_reset();
        use_ovr = 1'b0;
        Enable  = 1'b1;
        Reset   = 1'b1;
        step(1);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Enable = 1'b1; use_ovr = 1'b1; ovr = ins(JMP, 11'h005);
        step(1);
        checks++; if (PC !== 11'h000) $display("FAIL reset_pc got %h want 000", PC); else passes++;
        checks++; if (Acc !== 16'h0000) $display("FAIL reset_acc got %h want 0000", Acc); else passes++;
        checks++; if (Halt !== 1'b0) $display("FAIL reset_halt got %b want 0", Halt); else passes++;
        checks++; if (Instr_Count !== 16'h0000) $display("FAIL reset_count got %h want 0000", Instr_Count); else passes++;
        Reset = 1'b0; use_ovr = 1'b0;
    endtask

    task automatic test_arith();
        clear_prog();
        prog[0] = ins(LDI, 11'd7); prog[1] = ins(STO, 11'd3); prog[2] = ins(LDI, 11'd0);
        prog[3] = ins(ADD, 11'd3); prog[4] = ins(ADDI, 11'h7FE);
        do_reset();
        step(5);
        checks++; if (Acc !== 16'h0005) $display("FAIL arith_acc got %h want 0005", Acc); else passes++;
        checks++; if (PC !== 11'h005) $display("FAIL arith_pc got %h want 005", PC); else passes++;
        checks++; if (Instr_Count !== 16'd5) $display("FAIL arith_count got %0d want 5", Instr_Count); else passes++;
    endtask

    task automatic test_logic();
        clear_prog();
        prog[0] = ins(LDI, 11'h0F0);  prog[1] = ins(STO, 11'd5);    prog[2] = ins(LDI, 11'h03C);
        prog[3] = ins(AND, 11'd5);    prog[4] = ins(ORI, 11'h700);  prog[5] = ins(XOR, 11'd5);
        prog[6] = ins(XORI, 11'h0FF); prog[7] = ins(SUB, 11'd5);    prog[8] = ins(ANDI, 11'h7F0);
        prog[9] = ins(OR, 11'd5);     prog[10] = ins(LD, 11'd5);
        do_reset();
        step(4);
        checks++; if (Acc !== 16'h0030) $display("FAIL logic_and got %h want 0030", Acc); else passes++;
        step(1);
        checks++; if (Acc !== 16'hFF30) $display("FAIL logic_ori_sext got %h want ff30", Acc); else passes++;
        step(4);
        checks++; if (Acc !== 16'hFE40) $display("FAIL logic_xor_sub_andi got %h want fe40", Acc); else passes++;
        step(1);
        checks++; if (Acc !== 16'hFEF0) $display("FAIL logic_or got %h want fef0", Acc); else passes++;
        step(1);
        checks++; if (Acc !== 16'h00F0) $display("FAIL logic_ld got %h want 00f0", Acc); else passes++;
    endtask

    task automatic test_branch();
        clear_prog();
        prog[0] = ins(LDI, 11'd0);    prog[1] = ins(BEQ, 11'h010);
        prog[16] = ins(LDI, 11'd1);   prog[17] = ins(BNE, 11'h000);
        do_reset();
        step(2);
        checks++; if (PC !== 11'h010) $display("FAIL beq_taken got %h want 010", PC); else passes++;
        step(2);
        checks++; if (PC !== 11'h000) $display("FAIL bne_taken got %h want 000", PC); else passes++;
        prog[0] = ins(LDI, 11'd1);    prog[1] = ins(BEQ, 11'h020);
        step(2);
        checks++; if (PC !== 11'h002) $display("FAIL beq_not_taken got %h want 002", PC); else passes++;
        checks++; if (Instr_Count !== 16'd6) $display("FAIL branch_count got %0d want 6", Instr_Count); else passes++;
    endtask

    task automatic test_wrap();
        clear_prog();
        prog[0] = ins(LDI, 11'd0); prog[1] = ins(SUBI, 11'd1); prog[2] = ins(JMP, 11'h7FF);
        do_reset();
        step(2);
        checks++; if (Acc !== 16'hFFFF) $display("FAIL sub_wrap got %h want ffff", Acc); else passes++;
        step(1);
        checks++; if (PC !== 11'h7FF) $display("FAIL jmp got %h want 7ff", PC); else passes++;
        step(1);
        checks++; if (PC !== 11'h000) $display("FAIL pc_wrap got %h want 000", PC); else passes++;
        checks++; if (Acc !== 16'hFFFF) $display("FAIL nop_acc got %h want ffff", Acc); else passes++;
    endtask

    task automatic test_halt();
        clear_prog();
        prog[0] = ins(LDI, 11'd9); prog[1] = ins(STO, 11'd6); prog[2] = ins(HLT, 11'h000);
        do_reset();
        step(3);
        checks++; if (Halt !== 1'b1) $display("FAIL halt_set got %b want 1", Halt); else passes++;
        use_ovr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            Enable = i[0];
            case (i % 3)
                0: ovr = ins(STO, 11'd6);
                1: ovr = ins(LDI, 11'h055);
                default: ovr = ins(JMP, 11'h100);
            endcase
            step(1);
            checks++;
            if (PC !== 11'h002 || Instr_Count !== 16'd3 || Halt !== 1'b1 || Acc !== 16'h0009)
                $display("FAIL halt_freeze cyc %0d got pc=%h cnt=%0d halt=%b acc=%h want 002/3/1/0009",
                         i, PC, Instr_Count, Halt, Acc);
            else passes++;
        end
        do_reset();
        checks++;
        if (PC !== 11'h000 || Acc !== 16'h0000 || Halt !== 1'b0 || Instr_Count !== 16'd0)
            $display("FAIL halt_reset got pc=%h acc=%h halt=%b cnt=%0d want all zero", PC, Acc, Halt, Instr_Count);
        else passes++;
        prog[0] = ins(LD, 11'd6);
        step(1);
        checks++; if (Acc !== 16'h0009) $display("FAIL mem_keep got %h want 0009", Acc); else passes++;
    endtask

    task automatic test_reset_sto();
        clear_prog();
        prog[0] = ins(LDI, 11'h123); prog[1] = ins(STO, 11'd7); prog[2] = ins(LDI, 11'h044);
        do_reset();
        step(3);
        Reset = 1'b1; use_ovr = 1'b1; ovr = ins(STO, 11'd7);
        step(1);
        Reset = 1'b0; use_ovr = 1'b0;
        prog[0] = ins(LD, 11'd7);
        step(1);
        checks++; if (Acc !== 16'h0123) $display("FAIL reset_sto got %h want 0123", Acc); else passes++;
    endtask

    task automatic test_stall();
        clear_prog();
        prog[0] = ins(LDI, 11'h021); prog[1] = ins(STO, 11'd8); prog[2] = ins(LDI, 11'h055);
        prog[3] = ins(LD, 11'd8);
        do_reset();
        step(3);
        Enable = 1'b0; use_ovr = 1'b1; ovr = ins(STO, 11'd8);
        for (int i = 0; i < 4; i++) begin
            step(1);
            checks++;
            if (PC !== 11'h003 || Acc !== 16'h0055 || Instr_Count !== 16'd3)
                $display("FAIL stall cyc %0d got pc=%h acc=%h cnt=%0d want 003/0055/3", i, PC, Acc, Instr_Count);
            else passes++;
        end
        Enable = 1'b1; use_ovr = 1'b0;
        step(1);
        checks++; if (Acc !== 16'h0021) $display("FAIL stall_ld got %h want 0021", Acc); else passes++;
        checks++; if (PC !== 11'h004) $display("FAIL stall_resume_pc got %h want 004", PC); else passes++;
    endtask

    task automatic test_saturate();
        clear_prog();
        do_reset();
        step(10);
        checks++; if (s_count !== 3'd7) $display("FAIL count_sat got %0d want 7", s_count); else passes++;
        checks++; if (s_pc !== 11'd10) $display("FAIL sat_pc got %0d want 10", s_pc); else passes++;
        checks++; if (Instr_Count !== 16'd10) $display("FAIL wide_count got %0d want 10", Instr_Count); else passes++;
    endtask

    initial begin
        Reset = 1'b0; Enable = 1'b0; use_ovr = 1'b0; ovr = '0;
        clear_prog();
        step(1);
        test_reset();
        test_arith();
        test_logic();
        test_branch();
        test_wrap();
        test_halt();
        test_reset_sto();
        test_stall();
        test_saturate();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
